ram_fill_loader: RTL and testbench

- Port-B write initiator for the system RAM.
- Performs a full-memory fill sweep on request, writing `fill_val` to every address.
- Streams downloaded image bytes (ROM/tape/snapshot) into RAM through a 2-entry FIFO.
- Raises `cpu_hold` while active so the CPU port stays quiet; honours a `ram_stall` backpressure input from port-B arbitration.

---
 rtl/ram_fill_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ram_fill_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fill_loader.sv
// ---------------------------------------------------------------------------
// ram_fill_loader
//
// Port-B write initiator for the system RAM. Two jobs share the port:
//   * fill sweep : on clear_req, writes the latched fill byte to every address
//                  from CLR_START to CLR_END (inclusive), one per free cycle.
//   * image load : while dl_active is high, downloaded bytes are queued in a
//                  2-entry FIFO and written at dl_addr + DL_OFFSET (mod 2^16).
// cpu_hold is raised while either job is active so the CPU port stays quiet.
// ram_stall from the port-B arbiter holds the pending item for a cycle.
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   asynchronous, active-high reset
//   clear_req  in   1-cycle pulse, starts (or restarts) a fill sweep
//   fill_val   in   fill byte, sampled when the sweep starts
//   dl_active  in   download window (level)
//   dl_wr      in   1-cycle byte strobe
//   dl_addr    in   byte address of the downloaded byte
//   dl_data    in   downloaded byte
//   ram_stall  in   port B unavailable this cycle
//   ram_ad_b   out  write address (registered)
//   ram_d_b    out  write data (registered)
//   ram_cs_b   out  write select, one cycle per write (registered)
//   ram_we_b   out  write enable, identical to ram_cs_b (registered)
//   cpu_hold   out  high whenever the loader is not idle (registered)
//   done       out  1-cycle pulse at the end of a sweep or a load (registered)
//   overflow   out  sticky, a byte was dropped; cleared on entry to LOAD
// ---------------------------------------------------------------------------
module ram_fill_loader #(
  parameter logic [15:0] CLR_START = 16'h0000,
  parameter logic [15:0] CLR_END   = 16'hFFFF,
  parameter logic [15:0] DL_OFFSET = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clear_req,
  input  logic [7:0]  fill_val,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        ram_stall,
  output logic [15:0] ram_ad_b,
  output logic [7:0]  ram_d_b,
  output logic        ram_cs_b,
  output logic        ram_we_b,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Controller state
  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic [7:0]  fill_r;
  logic [7:0]  fill_s;
  // Set in the cycle the CLR_END write is on the bus; the sweep then finishes.
  logic        clr_last_r;
  logic        clr_last_s;

  // Download FIFO (2 entries, pointer based)
  logic [15:0] fifo_ad_r [2];
  logic [7:0]  fifo_d_r  [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  fifo_cnt_r;
  logic [1:0]  fifo_cnt_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic [15:0] push_ad_s;

  // Per-cycle decisions
  logic        push_s;
  logic        pop_s;
  logic        drop_s;
  logic        ovf_clr_s;
  logic        done_s;
  logic        issue_s;
  logic [15:0] issue_ad_s;
  logic [7:0]  issue_d_s;

  // Registered outputs
  logic [15:0] ad_r;
  logic [7:0]  d_r;
  logic        wr_en_r;
  logic        hold_r;
  logic        done_r;
  logic        ovf_r;

  // FIFO status and the offset address of an incoming byte
  always_comb begin
    fifo_empty_s = (fifo_cnt_r == 2'd0);
    fifo_full_s  = (fifo_cnt_r == 2'd2);
    push_ad_s    = dl_addr + DL_OFFSET;
  end

  // Next-state and write-issue decisions for the loader
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    fill_s     = fill_r;
    clr_last_s = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    drop_s     = 1'b0;
    ovf_clr_s  = 1'b0;
    done_s     = 1'b0;
    issue_s    = 1'b0;
    issue_ad_s = ad_r;
    issue_d_s  = d_r;

    case (state_r)
      ST_IDLE: begin
        // A fill request wins over an open download window.
        if (clear_req) begin
          state_s = ST_CLEAR;
          fill_s  = fill_val;
          cnt_s   = CLR_START;
        end else if (dl_active) begin
          state_s   = ST_LOAD;
          ovf_clr_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        // The sweep owns the port; download bytes cannot be queued.
        drop_s = dl_wr;
        if (clear_req) begin
          cnt_s  = CLR_START;
          fill_s = fill_val;
        end else if (clr_last_r) begin
          done_s  = 1'b1;
          cnt_s   = CLR_START;
          state_s = ST_IDLE;
        end else if (!ram_stall) begin
          issue_s    = 1'b1;
          issue_ad_s = cnt_r;
          issue_d_s  = fill_r;
          // Stop at CLR_END rather than wrapping the counter.
          if (cnt_r == CLR_END) begin
            clr_last_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_LOAD: begin
        pop_s  = !ram_stall && !fifo_empty_s;
        // A full FIFO still accepts a byte when an entry leaves this cycle.
        push_s = dl_wr && (!fifo_full_s || pop_s);
        drop_s = dl_wr && !push_s;
        if (!dl_active) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_DRAIN: begin
        pop_s  = !ram_stall && !fifo_empty_s;
        drop_s = dl_wr;
        // An empty FIFO here means the last pop is already on the bus.
        if (dl_active) begin
          state_s   = ST_LOAD;
          ovf_clr_s = 1'b1;
        end else if (fifo_empty_s) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (pop_s) begin
      issue_s    = 1'b1;
      issue_ad_s = fifo_ad_r[rd_ptr_r];
      issue_d_s  = fifo_d_r[rd_ptr_r];
    end else begin
      issue_s = issue_s;
    end
  end

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    fifo_cnt_s = fifo_cnt_r;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_s = fifo_cnt_r + 2'd1;
      2'b01:   fifo_cnt_s = fifo_cnt_r - 2'd1;
      default: fifo_cnt_s = fifo_cnt_r;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fifo_ad_r[0] <= 16'h0000;
      fifo_ad_r[1] <= 16'h0000;
      fifo_d_r[0]  <= 8'h00;
      fifo_d_r[1]  <= 8'h00;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      fifo_cnt_r   <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_ad_r[wr_ptr_r] <= push_ad_s;
        fifo_d_r[wr_ptr_r]  <= dl_data;
        wr_ptr_r            <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_s;
    end
  end

  // Controller state, sweep counter and registered port-B outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CLR_START;
      fill_r     <= 8'h00;
      clr_last_r <= 1'b0;
      ad_r       <= 16'h0000;
      d_r        <= 8'h00;
      wr_en_r    <= 1'b0;
      hold_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      fill_r     <= fill_s;
      clr_last_r <= clr_last_s;
      ad_r       <= issue_ad_s;
      d_r        <= issue_d_s;
      wr_en_r    <= issue_s;
      hold_r     <= (state_s != ST_IDLE);
      done_r     <= done_s;
      // A dropped byte in the same cycle as a LOAD entry is still reported.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign ram_ad_b = ad_r;
  assign ram_d_b  = d_r;
  assign ram_cs_b = wr_en_r;
  assign ram_we_b = wr_en_r;
  assign cpu_hold = hold_r;
  assign done     = done_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_ram_fill_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_fill_loader
//
// Self-checking bench for ram_fill_loader (CLR_START=0, CLR_END=0xFFFF,
// DL_OFFSET=0xC000). Download traffic is checked against a queue-based
// reference: accepted bytes form an ordered list of expected writes, each
// tagged with the cycle it should appear on port B.
// ---------------------------------------------------------------------------
module tb_ram_fill_loader;

  localparam logic [15:0] OFF = 16'hC000;
  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_DRAIN = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        clear_req;
  logic [7:0]  fill_val;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        ram_stall;
  logic [15:0] ram_ad_b;
  logic [7:0]  ram_d_b;
  logic        ram_cs_b;
  logic        ram_we_b;
  logic        cpu_hold;
  logic        done;
  logic        overflow;

  ram_fill_loader #(
    .CLR_START(16'h0000),
    .CLR_END  (16'hFFFF),
    .DL_OFFSET(OFF)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clear_req(clear_req),
    .fill_val (fill_val),
    .dl_active(dl_active),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .ram_stall(ram_stall),
    .ram_ad_b (ram_ad_b),
    .ram_d_b  (ram_d_b),
    .ram_cs_b (ram_cs_b),
    .ram_we_b (ram_we_b),
    .cpu_hold (cpu_hold),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed port-B activity
  logic [23:0] act_wr[$];
  int unsigned act_wr_cyc[$];
  int unsigned act_done[$];
  int          cs_we_diff = 0;
  int          hold_bad   = 0;

  always @(negedge clk_sys) begin
    if (ram_cs_b !== ram_we_b) cs_we_diff++;
    if (ram_we_b === 1'b1) begin
      act_wr.push_back({ram_ad_b, ram_d_b});
      act_wr_cyc.push_back(cyc);
      if (cpu_hold !== 1'b1) hold_bad++;
    end
    if (done === 1'b1) act_done.push_back(cyc);
  end

  // Reference model of the download path
  int          m_mode = M_IDLE;
  logic [23:0] m_q[$];
  logic [23:0] exp_wr[$];
  int unsigned exp_wr_cyc[$];
  int unsigned exp_done[$];
  logic        exp_ovf = 1'b0;

  task automatic clear_logs();
    act_wr.delete();
    act_wr_cyc.delete();
    act_done.delete();
    exp_wr.delete();
    exp_wr_cyc.delete();
    exp_done.delete();
    m_q.delete();
    m_mode = M_IDLE;
  endtask

  // Drive one cycle of download inputs (called just after a negedge) and
  // advance the reference by the clock edge that will sample them.
  task automatic step(input logic act, input logic wr, input logic [15:0] a,
                      input logic [7:0] d, input logic stl);
    int unsigned now;
    bit was_empty;
    now       = cyc;
    clear_req = 1'b0;
    dl_active = act;
    dl_wr     = wr;
    dl_addr   = a;
    dl_data   = d;
    ram_stall = stl;
    if (m_mode == M_IDLE) begin
      if (act) begin
        m_mode  = M_LOAD;
        exp_ovf = 1'b0;
      end
    end else begin
      was_empty = (m_q.size() == 0);
      if (!stl && m_q.size() > 0) begin
        exp_wr.push_back(m_q.pop_front());
        exp_wr_cyc.push_back(now + 1);
      end
      if (wr) begin
        if (m_mode == M_LOAD && m_q.size() < 2) m_q.push_back({a + OFF, d});
        else exp_ovf = 1'b1;
      end
      if (m_mode == M_LOAD) begin
        if (!act) m_mode = M_DRAIN;
      end else if (act) begin
        m_mode = M_LOAD;
        if (!wr) exp_ovf = 1'b0;
      end else if (was_empty) begin
        exp_done.push_back(now + 1);
        m_mode = M_IDLE;
      end
    end
    @(negedge clk_sys);
  endtask

  task automatic compare_run(input string tag);
    int n;
    check_val({tag, "_nwr"}, act_wr.size(), exp_wr.size());
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_wr"}, 32'(act_wr[i]), 32'(exp_wr[i]));
      check_val({tag, "_wrcyc"}, act_wr_cyc[i], exp_wr_cyc[i]);
    end
    check_val({tag, "_ndone"}, act_done.size(), exp_done.size());
    n = (act_done.size() < exp_done.size()) ? act_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) check_val({tag, "_donecyc"}, act_done[i], exp_done[i]);
    check_val({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    bit          hit;
    bit          done_seen;
    int          bad;
    int          stall_left;
    int unsigned start_cyc;
    int unsigned done_c;
    logic [7:0]  fv;

    reset     = 1'b1;
    clear_req = 1'b0;
    fill_val  = 8'h00;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = 16'h0000;
    dl_data   = 8'h00;
    ram_stall = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_sys);
    check_val("rst_ad", 32'(ram_ad_b), 32'h0);
    check_val("rst_d", 32'(ram_d_b), 32'h0);
    check_val("rst_we_cs", 32'({ram_we_b, ram_cs_b}), 32'h0);
    check_val("rst_hold_done_ovf", 32'({cpu_hold, done, overflow}), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Asynchronous reset in the middle of a sweep
    fv        = 8'($urandom);
    fill_val  = fv;
    clear_req = 1'b1;
    @(negedge clk_sys);
    clear_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (ram_we_b === 1'b1 && ram_ad_b === 16'h00FF) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("rst_trigger", 32'(hit), 32'h1);
    check_val("sweep_fill_byte", 32'(ram_d_b), 32'(fv));
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_ad", 32'(ram_ad_b), 32'h0);
    check_val("async_rst_d", 32'(ram_d_b), 32'h0);
    check_val("async_rst_we_cs", 32'({ram_we_b, ram_cs_b}), 32'h0);
    check_val("async_rst_hold", 32'(cpu_hold), 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    #1 clear_logs();
    repeat (20) @(negedge clk_sys);
    check_val("post_rst_nwr", act_wr.size(), 32'h0);
    check_val("post_rst_hold", 32'(cpu_hold), 32'h0);

    // Two consecutive bytes, then close the window
    clear_logs();
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    step(1'b1, 1'b1, 16'h0000, 8'h11, 1'b0);
    step(1'b1, 1'b1, 16'h0001, 8'h22, 1'b0);
    step(1'b1, 1'b1, 16'h4001, 8'h33, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    if (act_wr.size() > 1) begin
      check_val("dl_first", 32'(act_wr[0]), 32'h00C00011);
      check_val("dl_second", 32'(act_wr[1]), 32'h00C00122);
    end else begin
      check_val("dl_first_present", act_wr.size(), 32'h2);
    end
    compare_run("dl_basic");

    // Stalled port: third byte does not fit
    clear_logs();
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(1'b1, 1'b1, 16'h0100, 8'hA1, 1'b1);
    step(1'b1, 1'b1, 16'h0101, 8'hA2, 1'b1);
    step(1'b1, 1'b1, 16'h0102, 8'hA3, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1);
    check_val("stall_ovf", 32'(overflow), 32'h1);
    check_val("stall_nwr", act_wr.size(), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    compare_run("dl_stall");

    // Randomized load with random stalls, strobes and a drain-time drop
    clear_logs();
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 80; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
           ($urandom_range(0, 2) == 0));
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
    step(1'b0, 1'b1, 16'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    compare_run("dl_random");

    // Full sweep requested together with a download window
    clear_logs();
    fill_val   = 8'hFF;
    clear_req  = 1'b1;
    dl_active  = 1'b1;
    start_cyc  = cyc;
    stall_left = 0;
    done_seen  = 1'b0;
    done_c     = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk_sys);
      clear_req = 1'b0;
      dl_wr     = (i == 50);
      dl_addr   = 16'h0042;
      if (i == 60) check_val("sweep_ovf", 32'(overflow), 32'h1);
      if (ram_we_b === 1'b1 && ram_ad_b === 16'h1233) stall_left = 5;
      if (stall_left > 0) begin
        ram_stall = 1'b1;
        stall_left--;
      end else begin
        ram_stall = 1'b0;
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        done_c    = cyc;
        break;
      end
    end
    #1;
    dl_wr     = 1'b0;
    ram_stall = 1'b0;
    check_val("sweep_done_seen", 32'(done_seen), 32'h1);
    check_val("sweep_nwr", act_wr.size(), 32'd65536);
    if (act_wr.size() == 65536) begin
      bad = 0;
      for (int i = 0; i < 65536; i++)
        if (act_wr[i] !== {i[15:0], 8'hFF}) bad++;
      check_val("sweep_addr_data", 32'(bad), 32'h0);
      bad = 0;
      for (int i = 0; i < 65535; i++)
        if (i != 16'h1233 && act_wr_cyc[i + 1] - act_wr_cyc[i] != 1) bad++;
      check_val("sweep_gaps", 32'(bad), 32'h0);
      check_val("sweep_stall_gap", act_wr_cyc[16'h1234] - act_wr_cyc[16'h1233], 32'd6);
      check_val("sweep_first_cyc", act_wr_cyc[0], start_cyc + 2);
      check_val("sweep_done_cyc", done_c, act_wr_cyc[65535] + 1);
    end else begin
      check_val("sweep_analysis_skipped", 32'h1, 32'h0);
    end

    // Window still open: LOAD follows the sweep, overflow cleared on entry
    clear_logs();
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    check_val("after_sweep_ovf", 32'(overflow), 32'h0);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    check_val("after_sweep_hold", 32'(cpu_hold), 32'h1);
    step(1'b1, 1'b1, 16'h3FFF, 8'hA5, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    compare_run("post_sweep_load");

    check_val("cs_we_equal", 32'(cs_we_diff), 32'h0);
    check_val("hold_during_writes", 32'(hold_bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
